// File: rtl/rom_load_pkg.sv
// -----------------------------------------------------------------------------
// rom_load_pkg
// Shared types and constants for the ROM load controller.
//   state_e        : controller state encoding (IDLE / LOAD / FLUSH)
//   hdr_idx_w()    : width of the header read index for a given header length
//   HDR_BYTES_DFLT : default header length
//   HDR_IDX_W      : header index width for the default header length
// -----------------------------------------------------------------------------
package rom_load_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Header index width. It is never narrower than 1 bit, so the port still
  // exists when header capture is disabled or only a single byte is captured.
  function automatic int hdr_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int HDR_BYTES_DFLT = 16;
  localparam int HDR_IDX_W      = hdr_idx_w(HDR_BYTES_DFLT);

endpackage

// File: rtl/byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Synchronous FIFO with show-ahead read data. DEPTH must be a power of two
// and at least 2.
//   clk, resetn : clock, asynchronous active-low reset
//   push_i/din_i: write strobe and data (ignored when full)
//   pop_i       : consume the head entry (ignored when empty)
//   dout_o      : head entry, valid whenever empty_o is low
//   full_o      : no free entry
//   empty_o     : no stored entry
// -----------------------------------------------------------------------------
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit tells a full FIFO apart from an empty one.
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: storage arrays carry no reset; the pointers alone define which
  // entries are meaningful, and leaving the array unreset keeps it in plain RAM.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/rom_load_ctrl.sv
// -----------------------------------------------------------------------------
// rom_load_ctrl
// Turns the MCU ROM byte stream into 16-bit little-endian SDRAM writes.
// The first HDR_BYTES bytes of each load go to a readable header store; the
// rest are buffered in a byte FIFO, paired into words and written at
// consecutive word addresses starting from 0.
//
// Ports
//   clk, resetn              : clock, asynchronous active-low reset
//   rom_loading              : load window (rise starts, fall ends a load)
//   rom_do, rom_do_valid     : ROM byte and its single-cycle strobe
//   mem_req/mem_ack          : write handshake (req held until ack)
//   mem_addr/wdata/be        : word address, data (first byte low), enables
//   hdr_addr/hdr_data        : header read port, one cycle of latency
//   hdr_valid                : whole header captured
//   busy, done               : load/flush active; pulse on final write ack
//   rom_size                 : payload bytes written (saturating)
//   overflow                 : sticky, a payload byte was dropped
//   checksum                 : only with ROM_CHECKSUM_EN defined; 16-bit
//                              wrapping sum of payload bytes accepted
// Build option: `define ROM_CHECKSUM_EN adds the checksum output and adder.
// -----------------------------------------------------------------------------
module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter int ADDR_W     = 22,
  parameter int HDR_BYTES  = HDR_BYTES_DFLT,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            rom_loading,
  input  logic [7:0]                      rom_do,
  input  logic                            rom_do_valid,
  output logic                            mem_req,
  input  logic                            mem_ack,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [15:0]                     mem_wdata,
  output logic [1:0]                      mem_be,
  input  logic [hdr_idx_w(HDR_BYTES)-1:0] hdr_addr,
  output logic [7:0]                      hdr_data,
  output logic                            hdr_valid,
  output logic                            busy,
  output logic                            done,
  output logic [ADDR_W:0]                 rom_size,
`ifdef ROM_CHECKSUM_EN
  output logic [15:0]                     checksum,
`endif
  output logic                            overflow
);

  localparam int IDX_W     = hdr_idx_w(HDR_BYTES);
  localparam int HCW       = hdr_idx_w(HDR_BYTES + 1);  // counts 0..HDR_BYTES
  localparam int HDR_DEPTH = 1 << IDX_W;
  localparam logic [HCW-1:0] HDR_N    = HCW'(HDR_BYTES);
  localparam logic [HCW-1:0] HDR_LAST = HCW'((HDR_BYTES > 0) ? HDR_BYTES - 1 : 0);

  state_e            state_q, state_d;
  logic              loading_q;
  logic              load_start, done_d, done_q;
  logic [HCW-1:0]    hdr_cnt_q;
  logic              hdr_valid_q;
  logic [7:0]        hdr_data_q;
  logic [7:0]        hdr_mem [HDR_DEPTH];
  logic [7:0]        lo_q;
  logic              lo_vld_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [1:0]        be_q;
  logic [ADDR_W:0]   size_q;
  logic [ADDR_W+1:0] size_sum;
  logic              overflow_q;

  logic       rise, fall, strobe_ld, hdr_take, pay_strobe, push, pop;
  logic       odd_issue, ack_take;
  logic [7:0] f_rdata;
  logic       f_full, f_empty;

  assign rise       = rom_loading & ~loading_q;
  assign fall       = ~rom_loading & loading_q;
  assign strobe_ld  = rom_do_valid && (state_q == ST_LOAD);
  assign hdr_take   = strobe_ld && (hdr_cnt_q < HDR_N);
  assign pay_strobe = strobe_ld && !hdr_take;
  // A full FIFO refuses the byte even if the packer pops in the same cycle.
  assign push       = pay_strobe && !f_full;
  assign pop        = !req_q && !f_empty;
  assign odd_issue  = (state_q == ST_FLUSH) && f_empty && lo_vld_q && !req_q;
  assign ack_take   = req_q && mem_ack;

  assign size_sum = {1'b0, size_q} +
                    {{ADDR_W{1'b0}}, (be_q == 2'b11), (be_q != 2'b11)};

  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push),
    .din_i   (rom_do),
    .pop_i   (pop),
    .dout_o  (f_rdata),
    .full_o  (f_full),
    .empty_o (f_empty)
  );

  // NOTE: every signal driven here gets a default first so no path can leave
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    load_start = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: if (rise) begin
        state_d    = ST_LOAD;
        load_start = 1'b1;
      end
      ST_LOAD: if (fall) state_d = ST_FLUSH;
      // Finish on the ack of the last write so done lines up with mem_req
      // dropping; an empty flush finishes at once.
      ST_FLUSH: if (f_empty && !lo_vld_q && (!req_q || mem_ack)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (hdr_take) hdr_mem[hdr_cnt_q[IDX_W-1:0]] <= rom_do;
  end

  // NOTE: state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      loading_q   <= 1'b0;
      done_q      <= 1'b0;
      hdr_data_q  <= '0;
      hdr_cnt_q   <= '0;
      hdr_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      size_q      <= '0;
      addr_q      <= '0;
      lo_q        <= '0;
      lo_vld_q    <= 1'b0;
      req_q       <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
    end else begin
      state_q    <= state_d;
      loading_q  <= rom_loading;
      done_q     <= done_d;
      hdr_data_q <= hdr_mem[hdr_addr];
      if (load_start) begin
        hdr_cnt_q   <= '0;
        hdr_valid_q <= 1'b0;
        overflow_q  <= 1'b0;
        size_q      <= '0;
        addr_q      <= '0;
        lo_vld_q    <= 1'b0;
      end else begin
        if (hdr_take) begin
          hdr_cnt_q <= hdr_cnt_q + 1'b1;
          if (hdr_cnt_q == HDR_LAST) hdr_valid_q <= 1'b1;
        end
        if (pay_strobe && f_full) overflow_q <= 1'b1;
        if (pop) begin
          if (!lo_vld_q) begin
            lo_q     <= f_rdata;
            lo_vld_q <= 1'b1;
          end else begin
            wdata_q  <= {f_rdata, lo_q};
            be_q     <= 2'b11;
            req_q    <= 1'b1;
            lo_vld_q <= 1'b0;
          end
        end else if (odd_issue) begin
          wdata_q  <= {8'h00, lo_q};
          be_q     <= 2'b01;
          req_q    <= 1'b1;
          lo_vld_q <= 1'b0;
        end
        if (ack_take) begin
          req_q  <= 1'b0;
          addr_q <= addr_q + 1'b1;
          size_q <= size_sum[ADDR_W+1] ? '1 : size_sum[ADDR_W:0];
        end
      end
    end
  end

`ifdef ROM_CHECKSUM_EN
  logic [15:0] csum_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)         csum_q <= '0;
    else if (load_start) csum_q <= '0;
    else if (push)       csum_q <= csum_q + {8'h00, rom_do};
  end
  assign checksum = csum_q;
`endif

  assign mem_req   = req_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign hdr_data  = hdr_data_q;
  assign hdr_valid = hdr_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign rom_size  = size_q;
  assign overflow  = overflow_q;

endmodule
